// File: rtl/l4_operand_feeder_if.sv
// Bundles the byte-stream input and the assembled-tile output of the operand feeder.
// The master side drives the upstream byte stream and the downstream consume signal.
// The slave side is the feeder itself.
interface l4_operand_feeder_if #(
  parameter int A_BYTES = 64,
  parameter int W_BYTES = 64
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic [3:0]             in_prec;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*A_BYTES-1:0]   a_flat;
  logic [8*W_BYTES-1:0]   w_flat;
  logic [3:0]             prec;

  modport master (
    output in_valid, in_data, in_prec, out_ready,
    input  in_ready, out_valid, a_flat, w_flat, prec
  );

  modport slave (
    input  in_valid, in_data, in_prec, out_ready,
    output in_ready, out_valid, a_flat, w_flat, prec
  );
endinterface

// File: rtl/l4_operand_feeder.sv
// Operand feeder: collects A_BYTES activation bytes, then W_BYTES weight bytes,
// from a byte stream and presents them as one flat tile to the multiplier top.
// The tile is held stable until the consumer takes it; the tile counter then advances.
module l4_operand_feeder #(
  parameter int A_BYTES = 64,
  parameter int W_BYTES = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  l4_operand_feeder_if.slave   bus,
  output logic [CNT_W-1:0]     tile_cnt,
  output logic                 busy
);

  localparam int DATA_W = 8;
  localparam int MAX_B  = (A_BYTES > W_BYTES) ? A_BYTES : W_BYTES;
  localparam int IDX_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;
  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(A_BYTES - 1);
  localparam logic [IDX_W-1:0] W_LAST = IDX_W'(W_BYTES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_W, HOLD} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic                      xfer;
  logic [DATA_W*A_BYTES-1:0] a_q;
  logic [DATA_W*W_BYTES-1:0] w_q;
  logic [3:0]                prec_q;

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign xfer          = bus.in_valid && (state != HOLD);
  assign busy          = !((state == LOAD_A) && (idx == '0));
  assign bus.a_flat    = a_q;
  assign bus.w_flat    = w_q;
  assign bus.prec      = prec_q;

  // Control: sequence A load, W load, hold; latch precision on the first activation byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD_A;
      idx      <= '0;
      prec_q   <= '0;
      tile_cnt <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            if (idx == '0) prec_q <= bus.in_prec;
            if (idx == A_LAST) begin
              idx   <= '0;
              state <= LOAD_W;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (xfer) begin
            if (idx == W_LAST) begin
              idx   <= '0;
              state <= HOLD;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state    <= LOAD_A;
            tile_cnt <= tile_cnt + 1'b1;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  // Operand buffers: write the accepted byte into its slot; untouched slots keep old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      w_q <= '0;
    end else if (xfer) begin
      for (int k = 0; k < A_BYTES; k++) begin
        if ((state == LOAD_A) && (idx == IDX_W'(k))) a_q[DATA_W*k +: DATA_W] <= bus.in_data;
      end
      for (int k = 0; k < W_BYTES; k++) begin
        if ((state == LOAD_W) && (idx == IDX_W'(k))) w_q[DATA_W*k +: DATA_W] <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_l4_operand_feeder.sv
// Bench for l4_operand_feeder with 4+4 byte tiles and a 2-bit tile counter.
// A byte-count model predicts every output each cycle; directed literals pin the model.
module tb_l4_operand_feeder;

  localparam int A = 4;
  localparam int W = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] tile_cnt;
  logic          busy;

  l4_operand_feeder_if #(.A_BYTES(A), .W_BYTES(W)) bus ();

  l4_operand_feeder #(.A_BYTES(A), .W_BYTES(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tile_cnt (tile_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_n    = 0;     // bytes accepted in the current tile
  bit            m_hold = 1'b0;  // a complete tile is waiting for the consumer
  logic [7:0]    m_a [A];
  logic [7:0]    m_w [W];
  logic [3:0]    m_prec = '0;
  logic [CW-1:0] m_cnt  = '0;

  initial begin
    foreach (m_a[i]) m_a[i] = '0;
    foreach (m_w[i]) m_w[i] = '0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n = 0; m_hold = 1'b0; m_prec = '0; m_cnt = '0;
      foreach (m_a[i]) m_a[i] = '0;
      foreach (m_w[i]) m_w[i] = '0;
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_hold = 1'b0;
        m_n    = 0;
        m_cnt  = m_cnt + 1'b1;
      end
    end else if (bus.in_valid) begin
      if (m_n == 0) m_prec = bus.in_prec;
      if (m_n < A) m_a[m_n] = bus.in_data;
      else         m_w[m_n - A] = bus.in_data;
      m_n++;
      if (m_n == A + W) m_hold = 1'b1;
    end
  end

  function automatic logic [8*A-1:0] model_a();
    logic [8*A-1:0] r;
    for (int i = 0; i < A; i++) r[8*i +: 8] = m_a[i];
    return r;
  endfunction

  function automatic logic [8*W-1:0] model_w();
    logic [8*W-1:0] r;
    for (int i = 0; i < W; i++) r[8*i +: 8] = m_w[i];
    return r;
  endfunction

  bit cmp_en = 1'b0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready",  64'(bus.in_ready),  64'(!m_hold));
      chk("m_out_valid", 64'(bus.out_valid), 64'(m_hold));
      chk("m_a_flat",    64'(bus.a_flat),    64'(model_a()));
      chk("m_w_flat",    64'(bus.w_flat),    64'(model_w()));
      chk("m_prec",      64'(bus.prec),      64'(m_prec));
      chk("m_tile_cnt",  64'(tile_cnt),      64'(m_cnt));
      chk("m_busy",      64'(busy),          64'(m_hold || (m_n != 0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] p);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_prec  = p;
    for (int g = 0; g < 50 && !done; g++) begin
      done = bus.in_ready;
      tick();
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    bus.in_prec  = 4'b0000;
  endtask

  task automatic send_tile(input logic [7:0] base, input logic [3:0] p);
    for (int i = 0; i < A + W; i++) send(base + 8'(i), p);
    idle();
  endtask

  logic [CW-1:0] wrap_exp [5];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_prec = '0; bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_tile_cnt",  64'(tile_cnt),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Streaming tile, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send(8'(i), 4'b1011);
    chk("stream_busy_mid", 64'(busy), 64'd1);
    chk("stream_ov_pre",   64'(bus.out_valid), 64'd0);
    send(8'h08, 4'b1011);
    idle();
    chk("stream_ov",     64'(bus.out_valid), 64'd1);
    chk("stream_a_flat", 64'(bus.a_flat), 64'h04030201);
    chk("stream_w_flat", 64'(bus.w_flat), 64'h08070605);
    chk("stream_prec",   64'(bus.prec),   64'(4'b1011));
    tick();
    chk("stream_ov_post", 64'(bus.out_valid), 64'd0);
    chk("stream_cnt",     64'(tile_cnt), 64'd1);

    // Backpressure: consumer stalls for 5 cycles, stray in_valid in HOLD is ignored
    bus.out_ready = 1'b0;
    send_tile(8'h11, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_ov",       64'(bus.out_valid), 64'd1);
      chk("bp_a_flat",   64'(bus.a_flat), 64'h14131211);
      chk("bp_w_flat",   64'(bus.w_flat), 64'h18171615);
      if (c == 2) begin
        bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.in_prec = 4'b1111;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    chk("bp_ov_last", 64'(bus.out_valid), 64'd1);
    tick();
    chk("bp_ov_after", 64'(bus.out_valid), 64'd0);
    chk("bp_cnt",      64'(tile_cnt), 64'd2);
    chk("bp_a_kept",   64'(bus.a_flat), 64'h14131211);
    chk("bp_prec",     64'(bus.prec), 64'(4'b0010));

    // Bubbles with precision change after byte 0
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), (i == 1) ? 4'b1011 : 4'b0000);
      if (i < 8) begin
        idle();
        tick();
      end
    end
    idle();
    chk("bub_ov",     64'(bus.out_valid), 64'd1);
    chk("bub_a_flat", 64'(bus.a_flat), 64'h04030201);
    chk("bub_w_flat", 64'(bus.w_flat), 64'h08070605);
    chk("bub_prec",   64'(bus.prec), 64'(4'b1011));
    tick();
    chk("bub_cnt", 64'(tile_cnt), 64'd3);

    // Reset mid-operation, asserted between clock edges
    for (int i = 0; i < 6; i++) send(8'h21 + 8'(i), 4'b1110);
    idle();
    #2 rst = 1'b0;
    #1;
    chk("mrst_a_flat",   64'(bus.a_flat), 64'd0);
    chk("mrst_w_flat",   64'(bus.w_flat), 64'd0);
    chk("mrst_prec",     64'(bus.prec), 64'd0);
    chk("mrst_cnt",      64'(tile_cnt), 64'd0);
    chk("mrst_busy",     64'(busy), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Post-reset tile, then counter wrap over five tiles total
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    for (int t = 0; t < 5; t++) begin
      send_tile(8'h31 + 8'(8 * t), 4'b0011);
      if (t == 0) begin
        chk("post_a_flat", 64'(bus.a_flat), 64'h34333231);
        chk("post_w_flat", 64'(bus.w_flat), 64'h38373635);
        chk("post_prec",   64'(bus.prec), 64'(4'b0011));
      end
      tick();
      chk("wrap_cnt", 64'(tile_cnt), 64'(wrap_exp[t]));
    end

    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l4_operand_feeder.md
L4_OPERAND_FEEDER -- requirements
Module: l4_operand_feeder

Interface
REQ-001: Parameter A_BYTES, default 64; number of 8-bit activation operands per tile.
REQ-002: Parameter W_BYTES, default 64; number of 8-bit weight operands per tile.
REQ-003: Parameter CNT_W, default 16; width of the completed-tile counter.
REQ-004: Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005: Port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006: Port in_valid  input  1  upstream byte valid.
REQ-007: Port in_ready  output  1  feeder accepts a byte this cycle.
REQ-008: Port in_data  input  8  operand byte.
REQ-009: Port in_prec  input  4  precision code {act[1:0], wgt[1:0]}; 00 = 8b, 10 = 4b, 11 = 2b.
REQ-010: Port out_valid  output  1  assembled tile presented to the multiplier top.
REQ-011: Port out_ready  input  1  multiplier side consumes the tile.
REQ-012: Port a_flat  output  8*A_BYTES  activations; byte k at bits [8k+7:8k].
REQ-013: Port w_flat  output  8*W_BYTES  weights; byte k at bits [8k+7:8k].
REQ-014: Port prec  output  4  precision code latched for the presented tile.
REQ-015: Port tile_cnt  output  CNT_W  number of tiles handed off since reset.
REQ-016: Port busy  output  1  high in any state other than LOAD_A with byte index 0.

Function
REQ-017: The FSM SHALL have exactly three states: LOAD_A, LOAD_W and HOLD.
REQ-018: Byte transfer occurs on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 in LOAD_A and LOAD_W and 0 in HOLD, decoded from state only.
REQ-019: In LOAD_A, the accepted byte SHALL be written to a_flat slot idx, where idx is an internal counter starting at 0.
REQ-020: When idx=0 in LOAD_A, the feeder SHALL latch in_prec into prec on the same transfer; in_prec is ignored on all other cycles.
REQ-021: On the transfer at idx=A_BYTES-1, idx SHALL wrap to 0 and the state SHALL change to LOAD_W.
REQ-022: In LOAD_W, bytes SHALL fill w_flat slots 0..W_BYTES-1 in order; the transfer at idx=W_BYTES-1 SHALL move the state to HOLD and clear idx.
REQ-023: out_valid SHALL be 1 exactly while in HOLD, first rising in the cycle after the last weight transfer (1-cycle latency).
REQ-024: While out_valid=1, a_flat, w_flat and prec SHALL stay stable until the handshake.
REQ-025: A handshake (HOLD and out_ready=1) SHALL return the state to LOAD_A and increment tile_cnt by 1, wrapping from 2^CNT_W-1 to 0.
REQ-026: The first byte of the next tile can be accepted no earlier than the cycle after the handshake; a full tile therefore takes at least A_BYTES+W_BYTES+1 cycles.
REQ-027: Cycles with in_valid=0 SHALL leave idx, state and buffers unchanged (stall tolerance at any index).
REQ-028: out_ready asserted outside HOLD SHALL have no effect.
REQ-029: Buffer slots not yet rewritten for the current tile SHALL keep their previous-tile values; no implicit clearing occurs between tiles.

Reset
REQ-030: While rst=0, the block SHALL immediately, without waiting for a clock edge, force state to LOAD_A, idx to 0, out_valid to 0, in_ready to 1, busy to 0, and a_flat, w_flat, prec and tile_cnt to all zeros.
REQ-031: Reset asserted mid-load or in HOLD SHALL discard the partial or pending tile; tile_cnt SHALL not increment.
REQ-032: After rst returns to 1, the first transfer SHALL be treated as activation byte 0 with prec latched.

Verification
REQ-033: Streaming tile: A_BYTES=W_BYTES=4, in_prec=4'b1011, bytes 0x01..0x08 sent back-to-back, out_ready=1 -> out_valid is high for exactly one cycle, one cycle after byte 0x08; a_flat=0x04030201, w_flat=0x08070605, prec=4'b1011, tile_cnt=1.
REQ-034: Backpressure: same stream with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable for all 5 cycles; a later in_valid pulse during HOLD is not accepted; the handshake occurs on the cycle out_ready rises.
REQ-035: Bubbles: in_valid toggling 1/0 across a whole tile -> same a_flat/w_flat as the streaming case; out_valid appears one cycle after the 8th accepted byte.
REQ-036: Reset mid-operation: drive rst=0 between clock edges after 6 bytes -> outputs are zero with no clock edge; after release, a new 8-byte tile yields the new data and tile_cnt=1.
REQ-037: Counter wrap: CNT_W=2, five tiles handed off -> tile_cnt sequence 1,2,3,0,1.
REQ-038: Precision latch: in_prec changes after byte 0 of a tile -> prec holds the value sampled on byte 0.
